apb_strobe_arbiter: RTL and testbench
=====================================

APB_STROBE_ARBITER -- requirements
Module: apb_strobe_arbiter

Interface
REQ-001 SHALL provide parameter TIMEOUT, default 16, meaning ACCESS-phase cycles before a transfer aborts (legal 2..255).
REQ-002 SHALL provide pclk  input  1  clock; all logic on rising edge.
REQ-003 SHALL provide preset_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL provide req_valid  input  2  per-requester transfer request; bit n = requester n.
REQ-005 SHALL provide req_write  input  2  per-requester direction: 1 write, 0 read.
REQ-006 SHALL provide req_addr  input  64  requester n address in bits [32n+31:32n].
REQ-007 SHALL provide req_wdata  input  64  requester n write data in bits [32n+31:32n].
REQ-008 SHALL provide req_strb  input  4  requester n byte-count code in bits [2n+1:2n]: 00=1, 01=2, 10=3, 11=4 bytes.
REQ-009 SHALL provide req_done  output  2  one-cycle completion pulse per requester.
REQ-010 SHALL provide req_err  output  2  one-cycle timeout flag, coincident with req_done.
REQ-011 SHALL provide rdata  output  32  read data of the most recent completed read.
REQ-012 SHALL provide psel, penable, pwrite  output  1 each  APB control to slave.
REQ-013 SHALL provide paddr, pwdata  output  32 each  APB address/write data.
REQ-014 SHALL provide p_strobe  output  2  byte-count code forwarded to slave.
REQ-015 SHALL provide pready  input  1  slave ready; prdata  input  32  slave read data.

Function
REQ-016 SHALL implement FSM states IDLE, SETUP, ACCESS; all outputs registered.
REQ-017 In IDLE with any req_valid high, SHALL grant one requester, latch its write/addr/wdata/strb into APB output registers, go to SETUP next cycle.
REQ-018 Arbitration SHALL be round-robin: when both request, grant the requester not granted last; when one requests, grant it regardless of history.
REQ-019 Last-grant pointer SHALL update only on grant; reset value 1, so requester 0 wins the first contention.
REQ-020 SETUP SHALL last exactly one cycle: psel=1, penable=0; then ACCESS.
REQ-021 ACCESS SHALL hold psel=1, penable=1, paddr/pwdata/pwrite/p_strobe stable until exit.
REQ-022 On pready=1 sampled in ACCESS, SHALL pulse req_done[grant] next cycle, load rdata from prdata if read (rdata unchanged on write), drop psel/penable, return to IDLE.
REQ-023 ACCESS cycle counter SHALL start at 0 on SETUP->ACCESS entry, increment each ACCESS cycle without pready; at count TIMEOUT-1 without pready, SHALL pulse req_done[grant] and req_err[grant], force rdata=0 for reads, return to IDLE.
REQ-024 pready in the same cycle as timeout SHALL count as success (req_err=0).
REQ-025 SHALL leave IDLE occupied for at least one cycle between transfers (psel low ≥1 cycle), so back-to-back grants are SETUP-to-SETUP ≥4 cycles apart.
REQ-026 Requester SHALL hold req_valid and payload until req_done; deassertion after grant SHALL NOT abort the transfer.
REQ-027 req_valid deasserted in the req_done cycle SHALL NOT be re-granted; still high SHALL be eligible in the following IDLE arbitration.
REQ-028 pready outside ACCESS SHALL be ignored.
REQ-029 req_done/req_err SHALL never be asserted for more than one requester in a cycle.

Reset
REQ-030 preset_n low SHALL force IDLE, psel=penable=pwrite=0, paddr=pwdata=0, p_strobe=00, req_done=req_err=00, rdata=0, counter=0, pointer=1, immediately and asynchronously.
REQ-031 Reset mid-transfer SHALL abandon it without req_done; first grant after release follows REQ-019.

Verification
REQ-032 Single write: req_valid=01, write, addr 0x10, wdata 0xA5A5_1234, strb 11; pready high 2nd ACCESS cycle -> SETUP 1 cycle, ACCESS 2 cycles, req_done=01 one cycle, req_err=00.
REQ-033 Read: requester 1 read, prdata 0xDEAD_BEEF with pready on 1st ACCESS cycle -> rdata=0xDEAD_BEEF, req_done=10.
REQ-034 Contention: req_valid=11 held from reset, pready always 1 -> grant order 0,1,0,1; done pulses alternate.
REQ-035 Timeout: pready held 0, TIMEOUT=16 -> exactly 16 ACCESS cycles, then req_done and req_err for granter, rdata=0 if read.
REQ-036 Reset mid-ACCESS: preset_n low 1 cycle -> psel/penable 0 same cycle, no req_done, next contention grants requester 0.
REQ-037 Strobe forward: strb codes 00,01,10 -> p_strobe matches code through SETUP and ACCESS.

Source files
------------

// File: rtl/apb_strobe_arbiter_if.sv
// apb_strobe_arbiter_if: APB bus between the arbiter (master) and a single slave
interface apb_strobe_arbiter_if;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic [1:0]  p_strobe;
    logic        pready;
    logic [31:0] prdata;
    modport master (output psel, penable, pwrite, paddr, pwdata, p_strobe, input pready, prdata);
    modport slave  (input psel, penable, pwrite, paddr, pwdata, p_strobe, output pready, prdata);
endinterface

// File: rtl/apb_strobe_arbiter.sv
// apb_strobe_arbiter: round-robin arbiter of two requesters onto one APB slave with access timeout
module apb_strobe_arbiter #(
    parameter int TIMEOUT = 16
) (
    input  logic                  pclk,
    input  logic                  preset_n,
    input  logic [1:0]            req_valid,
    input  logic [1:0]            req_write,
    input  logic [63:0]           req_addr,
    input  logic [63:0]           req_wdata,
    input  logic [3:0]            req_strb,
    output logic [1:0]            req_done,
    output logic [1:0]            req_err,
    output logic [31:0]           rdata,
    apb_strobe_arbiter_if.master  apb
);
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;
    state_t     state, state_n;
    logic       last;
    logic       gnt;
    logic       sel;
    logic [7:0] cnt;
    logic       do_grant, do_ok, do_to;
    // state register
    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) state <= IDLE;
        else           state <= state_n;
    end
    // next state, arbitration choice and transfer-end decode; IDLE skips the done cycle so psel stays low a full cycle
    always_comb begin
        state_n  = state;
        do_grant = 1'b0;
        do_ok    = 1'b0;
        do_to    = 1'b0;
        sel      = (req_valid == 2'b11) ? ~last : req_valid[1];
        case (state)
            IDLE: begin
                if (|req_valid && ~|req_done) begin
                    do_grant = 1'b1;
                    state_n  = SETUP;
                end
            end
            SETUP: state_n = ACCESS;
            ACCESS: begin
                if (apb.pready) begin
                    do_ok   = 1'b1;
                    state_n = IDLE;
                end else if (cnt == 8'(TIMEOUT - 1)) begin
                    do_to   = 1'b1;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end
    // registered APB outputs, grant bookkeeping, access counter and completion reporting
    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            last         <= 1'b1;
            gnt          <= 1'b0;
            cnt          <= '0;
            req_done     <= '0;
            req_err      <= '0;
            rdata        <= '0;
            apb.psel     <= 1'b0;
            apb.penable  <= 1'b0;
            apb.pwrite   <= 1'b0;
            apb.paddr    <= '0;
            apb.pwdata   <= '0;
            apb.p_strobe <= '0;
        end else begin
            req_done <= '0;
            req_err  <= '0;
            if (do_grant) begin
                gnt          <= sel;
                last         <= sel;
                apb.psel     <= 1'b1;
                apb.penable  <= 1'b0;
                apb.pwrite   <= req_write[sel];
                apb.paddr    <= req_addr[{sel, 5'd0} +: 32];
                apb.pwdata   <= req_wdata[{sel, 5'd0} +: 32];
                apb.p_strobe <= req_strb[{sel, 1'b0} +: 2];
            end
            if (state == SETUP) begin
                apb.penable <= 1'b1;
                cnt         <= '0;
            end
            if (state == ACCESS && !do_ok && !do_to) cnt <= cnt + 8'd1;
            if (do_ok || do_to) begin
                apb.psel      <= 1'b0;
                apb.penable   <= 1'b0;
                req_done[gnt] <= 1'b1;
                req_err[gnt]  <= do_to;
                if (!apb.pwrite) rdata <= do_ok ? apb.prdata : 32'd0;
            end
        end
    end
endmodule

// File: tb/tb_apb_strobe_arbiter.sv
// tb_apb_strobe_arbiter: directed and randomized transfers checked against a transaction-level model
module tb_apb_strobe_arbiter;
    localparam int TIMEOUT = 16;
    logic        pclk = 1'b0;
    logic        preset_n = 1'b0;
    logic [1:0]  req_valid = '0;
    logic [1:0]  req_write = '0;
    logic [63:0] req_addr = '0;
    logic [63:0] req_wdata = '0;
    logic [3:0]  req_strb = '0;
    logic [1:0]  req_done, req_err;
    logic [31:0] rdata;
    int          checks = 0;
    int          fails = 0;
    logic        last_m = 1'b1;
    logic [31:0] rdata_m = '0;
    apb_strobe_arbiter_if apb();
    apb_strobe_arbiter #(.TIMEOUT(TIMEOUT)) dut (
        .pclk(pclk), .preset_n(preset_n), .req_valid(req_valid), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_strb(req_strb),
        .req_done(req_done), .req_err(req_err), .rdata(rdata), .apb(apb)
    );
    always #5 pclk = ~pclk;
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
    task automatic rand_req();
        req_write = 2'($urandom);
        req_addr  = {$urandom, $urandom};
        req_wdata = {$urandom, $urandom};
        req_strb  = 4'($urandom);
    endtask
    task automatic set_req(input int n, input logic w, input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
        req_write[n]          = w;
        req_addr[32*n +: 32]  = a;
        req_wdata[32*n +: 32] = d;
        req_strb[2*n +: 2]    = s;
    endtask
    task automatic apply_reset();
        @(negedge pclk);
        preset_n = 1'b0;
        @(negedge pclk);
        preset_n  = 1'b1;
        req_valid = '0;
        last_m    = 1'b1;
        rdata_m   = '0;
    endtask
    // one complete transfer; the slave raises pready on ACCESS cycle 'lat' (0-based)
    task automatic do_txn(input int lat, input logic [31:0] rd_val, input bit drop, input bit keep);
        int          t, acc, exp_acc, gi;
        logic        g, w, to;
        logic [31:0] a, d;
        logic [1:0]  s, oh;
        g       = (req_valid == 2'b11) ? ~last_m : req_valid[1];
        last_m  = g;
        gi      = int'(g);
        oh      = g ? 2'b10 : 2'b01;
        w       = req_write[gi];
        a       = req_addr[32*gi +: 32];
        d       = req_wdata[32*gi +: 32];
        s       = req_strb[2*gi +: 2];
        to      = lat >= TIMEOUT;
        exp_acc = to ? TIMEOUT : lat + 1;
        t = 0;
        do begin
            @(negedge pclk);
            t++;
        end while (!apb.psel && t < 10);
        checks++;
        if (t != 1) begin
            fails++;
            $display("FAIL grant_latency: psel after %0d cycles, required 1", t);
        end
        checks++;
        if ({apb.psel, apb.penable, apb.pwrite, apb.paddr, apb.pwdata, apb.p_strobe} !== {1'b1, 1'b0, w, a, d, s}) begin
            fails++;
            $display("FAIL setup: psel=%b penable=%b pwrite=%b paddr=%h pwdata=%h strobe=%b, required 1 0 %b %h %h %b",
                     apb.psel, apb.penable, apb.pwrite, apb.paddr, apb.pwdata, apb.p_strobe, w, a, d, s);
        end
        apb.pready = 1'($urandom);
        apb.prdata = $urandom;
        if (drop) req_valid[gi] = 1'b0;
        acc = 0;
        forever begin
            @(negedge pclk);
            if (!(apb.psel && apb.penable) || acc > TIMEOUT + 2) break;
            checks++;
            if ({apb.pwrite, apb.paddr, apb.pwdata, apb.p_strobe} !== {w, a, d, s}) begin
                fails++;
                $display("FAIL access_hold: pwrite=%b paddr=%h pwdata=%h strobe=%b, required %b %h %h %b",
                         apb.pwrite, apb.paddr, apb.pwdata, apb.p_strobe, w, a, d, s);
            end
            apb.pready = (acc == lat);
            apb.prdata = (acc == lat) ? rd_val : $urandom;
            acc++;
        end
        if (!w) rdata_m = to ? 32'd0 : rd_val;
        checks++;
        if (acc != exp_acc) begin
            fails++;
            $display("FAIL access_len: %0d ACCESS cycles, required %0d", acc, exp_acc);
        end
        checks++;
        if (req_done !== oh || req_err !== (to ? oh : 2'b00)) begin
            fails++;
            $display("FAIL done: req_done=%b req_err=%b, required %b %b", req_done, req_err, oh, to ? oh : 2'b00);
        end
        checks++;
        if (rdata !== rdata_m || apb.psel !== 1'b0) begin
            fails++;
            $display("FAIL rdata: rdata=%h psel=%b, required %h 0", rdata, apb.psel, rdata_m);
        end
        if (!keep) req_valid[gi] = 1'b0;
        apb.pready = 1'($urandom);
        @(negedge pclk);
        checks++;
        if (req_done !== 2'b00 || req_err !== 2'b00 || apb.psel !== 1'b0) begin
            fails++;
            $display("FAIL gap: req_done=%b req_err=%b psel=%b, required 00 00 0", req_done, req_err, apb.psel);
        end
        apb.pready = 1'b0;
    endtask
    task automatic test_reset();
        repeat (2) @(negedge pclk);
        checks++;
        if ({apb.psel, apb.penable, apb.pwrite, apb.paddr, apb.pwdata, apb.p_strobe, req_done, req_err, rdata} !== '0) begin
            fails++;
            $display("FAIL reset: psel=%b penable=%b pwrite=%b paddr=%h pwdata=%h strobe=%b done=%b err=%b rdata=%h, required all 0",
                     apb.psel, apb.penable, apb.pwrite, apb.paddr, apb.pwdata, apb.p_strobe, req_done, req_err, rdata);
        end
        preset_n = 1'b1;
    endtask
    task automatic test_single_write();
        set_req(0, 1'b1, 32'h10, 32'hA5A5_1234, 2'b11);
        req_valid = 2'b01;
        do_txn(1, 32'h0, 1'b0, 1'b0);
    endtask
    task automatic test_read();
        set_req(1, 1'b0, 32'h2000_0040, 32'h0, 2'b10);
        req_valid = 2'b10;
        do_txn(0, 32'hDEAD_BEEF, 1'b0, 1'b0);
    endtask
    task automatic test_contention();
        apply_reset();
        rand_req();
        req_valid = 2'b11;
        for (int i = 0; i < 4; i++) do_txn(0, $urandom, 1'b0, 1'b1);
        req_valid = 2'b00;
    endtask
    task automatic test_timeout();
        set_req(0, 1'b0, 32'h44, 32'h0, 2'b01);
        req_valid = 2'b01;
        do_txn(TIMEOUT + 40, 32'h1234_5678, 1'b0, 1'b0);
        set_req(1, 1'b0, 32'h48, 32'h0, 2'b00);
        req_valid = 2'b10;
        do_txn(TIMEOUT - 1, 32'hCAFE_F00D, 1'b0, 1'b0);
        set_req(0, 1'b1, 32'h4C, 32'h7777_0000, 2'b11);
        req_valid = 2'b01;
        do_txn(TIMEOUT, 32'h0, 1'b0, 1'b0);
    endtask
    task automatic test_strobe();
        for (int c = 0; c < 3; c++) begin
            set_req(c % 2, 1'b1, $urandom, $urandom, 2'(c));
            req_valid = (c % 2) ? 2'b10 : 2'b01;
            do_txn(2, 32'h0, 1'b0, 1'b0);
        end
    endtask
    task automatic test_reset_mid();
        int t;
        rand_req();
        req_valid  = 2'b11;
        apb.pready = 1'b0;
        t = 0;
        do begin
            @(negedge pclk);
            t++;
        end while (!apb.psel && t < 10);
        repeat (3) @(negedge pclk);
        preset_n = 1'b0;
        #1;
        checks++;
        if ({apb.psel, apb.penable, req_done, req_err, rdata} !== '0) begin
            fails++;
            $display("FAIL async_reset: psel=%b penable=%b done=%b err=%b rdata=%h, required all 0",
                     apb.psel, apb.penable, req_done, req_err, rdata);
        end
        @(negedge pclk);
        checks++;
        if (req_done !== 2'b00 || apb.psel !== 1'b0) begin
            fails++;
            $display("FAIL reset_hold: req_done=%b psel=%b, required 00 0", req_done, apb.psel);
        end
        preset_n = 1'b1;
        last_m   = 1'b1;
        rdata_m  = '0;
        do_txn(1, $urandom, 1'b0, 1'b0);
    endtask
    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            int lat;
            rand_req();
            req_valid = 2'($urandom_range(1, 3));
            lat = ($urandom_range(0, 7) == 0) ? int'($urandom_range(TIMEOUT - 2, TIMEOUT + 1)) : int'($urandom_range(0, 3));
            do_txn(lat, $urandom, 1'($urandom), 1'b0);
        end
    endtask
    initial begin
        apb.pready = 1'b0;
        apb.prdata = '0;
        test_reset();
        test_single_write();
        test_read();
        test_contention();
        test_timeout();
        test_strobe();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
